// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: ARF control codes, fetch FSM encoding and byte-assembly helper shared by the fetch path.
package cpu_defs_pkg;
    typedef enum logic [2:0] {FS_DEC = 3'b000, FS_INC = 3'b001, FS_LOAD = 3'b010, FS_CLR = 3'b011} funsel_e;
    typedef enum logic [2:0] {RS_PC = 3'b011, RS_NONE = 3'b111} regsel_e;
    typedef enum logic [1:0] {SEL_PC = 2'b00, SEL_AR = 2'b10, SEL_SP = 2'b11} outsel_e;
    typedef enum logic [1:0] {S_INIT, S_FETCH0, S_FETCH1, S_HOLD} fetch_state_e;
    function automatic logic [15:0] assemble(input logic lo_first, input logic [7:0] first, input logic [7:0] second);
        return lo_first ? {second, first} : {first, second};
    endfunction
endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// instruction_fetch_sequencer_if: memory, ARF-control and decoder handshake bundle of the fetch sequencer.
interface instruction_fetch_sequencer_if;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic        mem_read;
    logic [1:0]  arf_outdsel;
    logic [2:0]  arf_funsel;
    logic [2:0]  arf_regsel;
    logic        flush;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    modport master (
        input  mem_data, mem_ready, flush, instr_ready,
        output mem_read, arf_outdsel, arf_funsel, arf_regsel, instr, instr_valid
    );
    modport slave (
        output mem_data, mem_ready, flush, instr_ready,
        input  mem_read, arf_outdsel, arf_funsel, arf_regsel, instr, instr_valid
    );
endinterface

// File: rtl/fetch_instr_fifo.sv
// fetch_instr_fifo: in-order instruction queue of depth 1 or 2; the head always sits in slot 0.
module fetch_instr_fifo #(
    parameter int DEPTH = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [15:0] data_i,
    input  logic        pop_ready_i,
    output logic        pop_valid_o,
    output logic [15:0] data_o,
    output logic        full_next_o
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DEPTH*16-1:0] mem_q, mem_d;
    logic [CW-1:0] count_q, count_d;
    logic pop;
    assign pop_valid_o = count_q != '0;
    assign pop = pop_valid_o && pop_ready_i;
    assign data_o = mem_q[15:0];
    assign count_d = count_q + CW'(push_i) - CW'(pop);
    assign full_next_o = count_d == CW'(DEPTH);
    // Pop shifts toward slot 0 first, so a same-cycle push lands just behind the survivors.
    always_comb begin
        mem_d = pop ? mem_q >> 16 : mem_q;
        for (int i = 0; i < DEPTH; i++)
            if (push_i && i == int'(count_q) - int'(pop)) mem_d[i*16 +: 16] = data_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            mem_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer: PC-addressed byte fetch into 16-bit instructions handed over valid/ready.
// Define PREFETCH_EN for a 2-entry instruction queue that keeps fetching while the head waits.
module instruction_fetch_sequencer
    import cpu_defs_pkg::*;
#(
    parameter bit RESET_PC_CLEAR = 1'b1,
    parameter bit LO_FIRST = 1'b1
) (
    input logic clk_i,
    input logic rst_i,
    instruction_fetch_sequencer_if.master bus
);
`ifdef PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    fetch_state_e state_q, state_d;
    logic [7:0] byte0_q, byte0_d;
    logic [15:0] head_data, push_data;
    logic fetching, take, push, pop, head_valid, full_next, pc_clr, pc_wr;
    assign fetching = state_q == S_FETCH0 || state_q == S_FETCH1;
    assign take = fetching && bus.mem_ready && !bus.flush;
    assign push = take && state_q == S_FETCH1;
    assign pop = head_valid && bus.instr_ready && !bus.flush;
    assign push_data = assemble(LO_FIRST, byte0_q, bus.mem_data);
    always_comb begin
        state_d = state_q;
        byte0_d = byte0_q;
        if (bus.flush) state_d = S_FETCH0;
        else if (state_q == S_INIT) state_d = S_FETCH0;
        else if (take && state_q == S_FETCH0) begin
            state_d = S_FETCH1;
            byte0_d = bus.mem_data;
        end
        else if (push) state_d = full_next ? S_HOLD : S_FETCH0;
        else if (state_q == S_HOLD && pop) state_d = S_FETCH0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            byte0_q <= '0;
        end else begin
            state_q <= state_d;
            byte0_q <= byte0_d;
        end
    end
    // Reset and flush gate every ARF write so the PC never moves in those cycles.
    assign pc_clr = RESET_PC_CLEAR && state_q == S_INIT;
    assign pc_wr = !rst_i && (take || (pc_clr && !bus.flush));
    assign bus.arf_outdsel = SEL_PC;
    assign bus.arf_regsel = pc_wr ? RS_PC : RS_NONE;
    assign bus.arf_funsel = !pc_wr ? FS_DEC : take ? FS_INC : FS_CLR;
    assign bus.mem_read = !rst_i && !bus.flush && fetching;
    assign bus.instr_valid = !rst_i && !bus.flush && head_valid;
    assign bus.instr = rst_i ? '0 : head_data;
    fetch_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (bus.flush),
        .push_i      (push),
        .data_i      (push_data),
        .pop_ready_i (bus.instr_ready && !bus.flush),
        .pop_valid_o (head_valid),
        .data_o      (head_data),
        .full_next_o (full_next)
    );
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb_instruction_fetch_sequencer: directed checks of fetch timing, stalls, flush, reset and byte order.
module tb_instruction_fetch_sequencer;
`ifdef PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] pc = 8'h55;
    int n_chk = 0;
    int n_fail = 0;
    int base = 4;
    instruction_fetch_sequencer_if bus();
    instruction_fetch_sequencer_if bus2();
    instruction_fetch_sequencer dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    instruction_fetch_sequencer #(.RESET_PC_CLEAR(1'b0), .LO_FIRST(1'b0)) dut_hi (.clk_i(clk), .rst_i(rst), .bus(bus2));
    always #5 clk = ~clk;
    // PC register of the address register file as steered by the sequencer
    always @(posedge clk)
        if (bus.arf_regsel == 3'b011)
            pc <= bus.arf_funsel == 3'b001 ? pc + 8'd1 : bus.arf_funsel == 3'b011 ? 8'd0 : pc;
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(negedge clk);
    endtask
    task automatic set(input logic rdy, input logic [7:0] d, input logic irdy, input logic fl);
        bus.mem_ready = rdy;
        bus.mem_data = d;
        bus.instr_ready = irdy;
        bus.flush = fl;
        #1;
    endtask
    initial begin
        bus.mem_ready = 1'b0; bus.mem_data = '0; bus.instr_ready = 1'b0; bus.flush = 1'b0;
        bus2.mem_ready = 1'b0; bus2.mem_data = '0; bus2.instr_ready = 1'b0; bus2.flush = 1'b0;
        cyc(); #1;
        chk("rst_rd", bus.mem_read, 0);
        chk("rst_rs", bus.arf_regsel, 3'b111);
        chk("rst_fs", bus.arf_funsel, 3'b000);
        chk("rst_ods", bus.arf_outdsel, 2'b00);
        chk("rst_instr", bus.instr, 16'h0000);
        chk("rst_valid", bus.instr_valid, 0);
        // basic fetch: INIT clears PC, two zero-wait bytes, valid on cycle 4
        cyc(); rst = 1'b0; set(1'b0, 8'h00, 1'b1, 1'b0);
        chk("init_rs", bus.arf_regsel, 3'b011);
        chk("init_fs", bus.arf_funsel, 3'b011);
        chk("init_rd", bus.mem_read, 0);
        cyc(); set(1'b1, 8'h34, 1'b1, 1'b0);
        chk("f0_pc", pc, 0);
        chk("f0_rd", bus.mem_read, 1);
        chk("f0_rs", bus.arf_regsel, 3'b011);
        chk("f0_fs", bus.arf_funsel, 3'b001);
        chk("f0_valid", bus.instr_valid, 0);
        cyc(); set(1'b1, 8'h12, 1'b1, 1'b0);
        chk("f1_pc", pc, 1);
        chk("f1_rs", bus.arf_regsel, 3'b011);
        chk("f1_valid", bus.instr_valid, 0);
        cyc(); set(1'b0, 8'h00, 1'b1, 1'b0);
        chk("hold_valid", bus.instr_valid, 1);
        chk("hold_instr", bus.instr, 16'h1234);
        chk("hold_rd", bus.mem_read, PF);
        chk("hold_rs", bus.arf_regsel, 3'b111);
        chk("hold_pc", pc, 2);
        // memory wait states inside FETCH1
        cyc(); set(1'b1, 8'h78, 1'b0, 1'b0);
        chk("w_f0_rd", bus.mem_read, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(); set(1'b0, 8'hEE, 1'b0, 1'b0);
            chk("stall_rd", bus.mem_read, 1);
            chk("stall_rs", bus.arf_regsel, 3'b111);
            chk("stall_valid", bus.instr_valid, 0);
        end
        cyc(); set(1'b1, 8'h56, 1'b0, 1'b0);
        chk("w_f1_rs", bus.arf_regsel, 3'b011);
        chk("w_f1_pc", pc, 3);
        // decoder back-pressure
`ifdef PREFETCH_EN
        cyc(); set(1'b1, 8'h11, 1'b0, 1'b0);
        chk("bp_instr", bus.instr, 16'h5678);
        chk("bp_rd", bus.mem_read, 1);
        cyc(); set(1'b1, 8'h22, 1'b0, 1'b0);
        chk("bp_valid", bus.instr_valid, 1);
        chk("bp_rd", bus.mem_read, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(); set(1'b0, 8'h00, 1'b0, 1'b0);
            chk("bp_full_valid", bus.instr_valid, 1);
            chk("bp_full_instr", bus.instr, 16'h5678);
            chk("bp_full_rd", bus.mem_read, 0);
        end
        cyc(); set(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_pop0", bus.instr, 16'h5678);
        cyc(); set(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_pop1_valid", bus.instr_valid, 1);
        chk("bp_pop1", bus.instr, 16'h2211);
        base = 6;
`else
        for (int i = 0; i < 4; i++) begin
            cyc(); set(1'b0, 8'h00, 1'b0, 1'b0);
            chk("bp_valid", bus.instr_valid, 1);
            chk("bp_instr", bus.instr, 16'h5678);
            chk("bp_rd", bus.mem_read, 0);
        end
        cyc(); set(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_pop", bus.instr, 16'h5678);
`endif
        chk("bp_pc", pc, 16'(base));
        // flush coinciding with the second byte
        cyc(); set(1'b1, 8'h9A, 1'b0, 1'b0);
        chk("fl_f0_rd", bus.mem_read, 1);
        cyc(); set(1'b1, 8'hBC, 1'b1, 1'b1);
        chk("fl_rs", bus.arf_regsel, 3'b111);
        chk("fl_fs", bus.arf_funsel, 3'b000);
        chk("fl_valid", bus.instr_valid, 0);
        cyc(); set(1'b1, 8'h01, 1'b1, 1'b0);
        chk("fl_pc", pc, 16'(base + 1));
        chk("fl_after_valid", bus.instr_valid, 0);
        chk("fl_refetch_rs", bus.arf_regsel, 3'b011);
        cyc(); set(1'b1, 8'h02, 1'b1, 1'b0);
        chk("fl_f1_valid", bus.instr_valid, 0);
        cyc(); set(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fl_instr", bus.instr, 16'h0201);
        chk("fl_instr_valid", bus.instr_valid, 1);
        chk("fl_instr_rd", bus.mem_read, PF);
        chk("fl_instr_pc", pc, 16'(base + 3));
        // reset while an instruction is held
        cyc(); set(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(); set(1'b1, 8'hBB, 1'b0, 1'b0);
        cyc(); set(1'b0, 8'h00, 1'b0, 1'b0);
        chk("r_hold_valid", bus.instr_valid, 1);
        chk("r_hold_instr", bus.instr, 16'hBBAA);
        cyc(); rst = 1'b1; set(1'b1, 8'hCC, 1'b1, 1'b0);
        chk("r_valid", bus.instr_valid, 0);
        chk("r_instr", bus.instr, 16'h0000);
        chk("r_rs", bus.arf_regsel, 3'b111);
        chk("r_rd", bus.mem_read, 0);
        cyc(); rst = 1'b0; set(1'b0, 8'h00, 1'b0, 1'b0);
        chk("r_init_valid", bus.instr_valid, 0);
        chk("r_init_instr", bus.instr, 16'h0000);
        chk("r_init_rs", bus.arf_regsel, 3'b011);
        chk("r_init_fs", bus.arf_funsel, 3'b011);
        chk("noclr_rs", bus2.arf_regsel, 3'b111);
        chk("noclr_fs", bus2.arf_funsel, 3'b000);
        cyc(); #1;
        chk("r_pc", pc, 0);
        chk("r_f0_rd", bus.mem_read, 1);
        // high-byte-first instance
        cyc(); bus2.mem_ready = 1'b1; bus2.mem_data = 8'hAB; #1;
        chk("hi_rd", bus2.mem_read, 1);
        chk("hi_fs", bus2.arf_funsel, 3'b001);
        cyc(); bus2.mem_data = 8'hCD; #1;
        chk("hi_f1_valid", bus2.instr_valid, 0);
        cyc(); bus2.mem_ready = 1'b0; #1;
        chk("hi_valid", bus2.instr_valid, 1);
        chk("hi_instr", bus2.instr, 16'hABCD);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
